regfile_wb_queue: RTL and testbench

//  Write-side front end for the MiniCPU 4x4 register file. Accepts writeback

---
 rtl/regfile_wb_queue.sv | 110 +++++++++++
 tb/tb_regfile_wb_queue.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: writeback FIFO in front of the register file, with pending-write lookup.
// Optional macro WB_BYPASS_EN: forward the youngest pending value instead of raising hazard.
module regfile_wb_queue #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 2,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              drain_en,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data,
    input  logic [ADDR_W-1:0] lk_addr1,
    input  logic [ADDR_W-1:0] lk_addr2,
    output logic              lk_hit1,
    output logic              lk_hit2,
    output logic [DATA_W-1:0] lk_data1,
    output logic [DATA_W-1:0] lk_data2,
    output logic              hazard,
    output logic [ADDR_W:0]   count,
    output logic              empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = ADDR_W + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PW-1:0]     wp_q, wp_d, rp_q, rp_d, idx;
    logic [CW-1:0]     count_q, count_d;
    logic              push;
`ifdef WB_BYPASS_EN
    logic [DATA_W-1:0] byp1, byp2;
`endif

    always_comb begin
        empty      = count_q == '0;
        rf_we      = !empty && drain_en;
        rf_wr_addr = addr_q[rp_q];
        rf_wr_data = data_q[rp_q];
        in_ready   = (count_q < CW'(DEPTH)) || rf_we;
        push       = in_valid && in_ready;
        wp_d       = wp_q + PW'(push);
        rp_d       = rp_q + PW'(rf_we);
        count_d    = count_q + CW'(push) - CW'(rf_we);
        count      = count_q;
    end

    // Scan oldest to youngest so the youngest match overwrites earlier ones.
    always_comb begin
        lk_hit1 = 1'b0;
        lk_hit2 = 1'b0;
        idx     = rp_q;
`ifdef WB_BYPASS_EN
        byp1    = '0;
        byp2    = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            idx = rp_q + PW'(k);
            if (CW'(k) < count_q) begin
                if (addr_q[idx] == lk_addr1) begin
                    lk_hit1 = 1'b1;
`ifdef WB_BYPASS_EN
                    byp1    = data_q[idx];
`endif
                end
                if (addr_q[idx] == lk_addr2) begin
                    lk_hit2 = 1'b1;
`ifdef WB_BYPASS_EN
                    byp2    = data_q[idx];
`endif
                end
            end
        end
    end

`ifdef WB_BYPASS_EN
    assign lk_data1 = byp1;
    assign lk_data2 = byp2;
    assign hazard   = 1'b0;
`else
    assign lk_data1 = '0;
    assign lk_data2 = '0;
    assign hazard   = lk_hit1 | lk_hit2;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset; occupancy alone marks entries valid.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wp_q] <= in_addr;
            data_q[wp_q] <= in_data;
        end
    end
endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb_regfile_wb_queue: randomized and directed checks of regfile_wb_queue against a queue model.
// Expectations for lk_data/hazard follow WB_BYPASS_EN as defined for the build.
module tb_regfile_wb_queue;
    typedef struct packed {
        logic [1:0] a;
        logic [3:0] d;
    } ent_t;

    logic       clk, rst, in_valid, in_ready, drain_en, rf_we;
    logic       lk_hit1, lk_hit2, hazard, empty;
    logic [1:0] in_addr, rf_wr_addr, lk_addr1, lk_addr2;
    logic [3:0] in_data, rf_wr_data, lk_data1, lk_data2;
    logic [2:0] count;

    ent_t q[$];
    int total = 0;
    int bad = 0;

    regfile_wb_queue dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .drain_en(drain_en),
        .rf_we(rf_we), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .lk_addr1(lk_addr1), .lk_addr2(lk_addr2), .lk_hit1(lk_hit1),
        .lk_hit2(lk_hit2), .lk_data1(lk_data1), .lk_data2(lk_data2),
        .hazard(hazard), .count(count), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] look(input logic [1:0] la);
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].a == la) return {1'b1, q[i].d};
        return 5'd0;
    endfunction

    task automatic check_all();
        logic       we, rdy, h1, h2;
        logic [4:0] r1, r2;
        we  = q.size() != 0 && drain_en;
        rdy = q.size() < 4 || we;
        r1  = look(lk_addr1);
        r2  = look(lk_addr2);
        h1  = r1[4];
        h2  = r2[4];
        chk("count", 32'(count), 32'(q.size()));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("rf_we", 32'(rf_we), 32'(we));
        chk("in_ready", 32'(in_ready), 32'(rdy));
        if (q.size() != 0) begin
            chk("rf_wr_addr", 32'(rf_wr_addr), 32'(q[0].a));
            chk("rf_wr_data", 32'(rf_wr_data), 32'(q[0].d));
        end
        chk("lk_hit1", 32'(lk_hit1), 32'(h1));
        chk("lk_hit2", 32'(lk_hit2), 32'(h2));
`ifdef WB_BYPASS_EN
        chk("lk_data1", 32'(lk_data1), 32'(r1[3:0]));
        chk("lk_data2", 32'(lk_data2), 32'(r2[3:0]));
        chk("hazard", 32'(hazard), 32'd0);
`else
        chk("lk_data1", 32'(lk_data1), 32'd0);
        chk("lk_data2", 32'(lk_data2), 32'd0);
        chk("hazard", 32'(hazard), 32'(h1 | h2));
`endif
    endtask

    // One cycle: drive at edge+1, check mid-cycle, then advance the model across the edge.
    task automatic step(input logic v, input logic [1:0] a, input logic [3:0] d,
                        input logic de, input logic [1:0] l1, input logic [1:0] l2);
        logic acc, pop;
        ent_t e;
        in_valid = v;
        in_addr  = a;
        in_data  = d;
        drain_en = de;
        lk_addr1 = l1;
        lk_addr2 = l2;
        #2;
        check_all();
        pop = q.size() != 0 && de;
        acc = v && (q.size() < 4 || pop);
        e.a = a;
        e.d = d;
        @(posedge clk);
        #1;
        if (pop) void'(q.pop_front());
        if (acc) q.push_back(e);
    endtask

    task automatic mid_reset();
        in_valid = 1'b0;
        drain_en = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_hazard", 32'(hazard), 32'd0);
        #2;
        rst = 1'b0;
        q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_addr = '0;
        in_data = '0;
        drain_en = 1'b0;
        lk_addr1 = '0;
        lk_addr2 = '0;
        #2;
        chk("init_rf_we", 32'(rf_we), 32'd0);
        chk("init_empty", 32'(empty), 32'd1);
        chk("init_in_ready", 32'(in_ready), 32'd1);
        chk("init_hit1", 32'(lk_hit1), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        // T2 passthrough
        step(1, 2'd2, 4'hA, 1, 2'd2, 2'd0);
        step(0, 2'd0, 4'h0, 1, 2'd2, 2'd1);
        step(0, 2'd0, 4'h0, 1, 2'd2, 2'd1);
        // T3 fill and push-through-when-full
        for (int i = 0; i < 4; i++) step(1, 2'(i), 4'(i + 5), 0, 2'd3, 2'd1);
        step(1, 2'd1, 4'hF, 0, 2'd1, 2'd0);
        step(1, 2'd1, 4'hE, 1, 2'd1, 2'd2);
        step(0, 2'd0, 4'h0, 0, 2'd1, 2'd3);
        for (int i = 0; i < 5; i++) step(0, 2'd0, 4'h0, 1, 2'd1, 2'd0);
        // T4 youngest wins
        step(1, 2'd1, 4'd3, 0, 2'd1, 2'd2);
        step(1, 2'd1, 4'd7, 0, 2'd1, 2'd2);
        step(0, 2'd0, 4'd0, 0, 2'd1, 2'd2);
        step(0, 2'd0, 4'd0, 1, 2'd1, 2'd1);
        step(0, 2'd0, 4'd0, 1, 2'd1, 2'd1);
        // T5 wrap across pointer boundary
        for (int i = 0; i < 10; i++) step(1, 2'(i % 4), 4'(i), 1, 2'(i), 2'(i + 1));
        for (int i = 0; i < 3; i++) step(0, 2'd0, 4'd0, 1, 2'd0, 2'd1);
        // T1 reset mid-clock with entries pending
        for (int i = 0; i < 2; i++) step(1, 2'(i), 4'(i + 2), 0, 2'd0, 2'd1);
        mid_reset();
        // T6 reset mid-drain; nothing stale may commit afterwards
        for (int i = 0; i < 3; i++) step(1, 2'(3 - i), 4'(i + 9), 0, 2'd3, 2'd2);
        step(0, 2'd0, 4'd0, 1, 2'd3, 2'd2);
        mid_reset();
        for (int i = 0; i < 5; i++) step(0, 2'd0, 4'd0, 1, 2'(i), 2'd2);
        // Random traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 9) < 7, 2'($urandom), 4'($urandom),
                 $urandom_range(0, 1) == 1, 2'($urandom), 2'($urandom));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
